// File: rtl/AHB_package.sv
// ---------------------------------------------------------------------------
// AHB_package
// Shared AHB types for the per-master address decoder and its default slave.
//   htrans_type     : AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_type      : AHB slave response (OKAY/ERROR/RETRY/SPLIT)
//   def_slv_state_t : default-slave error sequencer states
// ---------------------------------------------------------------------------
package AHB_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_type;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } def_slv_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Answers accesses that hit no decoded region with the two-cycle AHB ERROR
// response (first cycle wait + ERROR, second cycle ready + ERROR).
// Ports:
//   hclk            in  clock
//   hreset_n        in  async active-low reset
//   default_slv_sel in  address phase targets an unmapped region
//   hready          in  global HREADY (address phase accepted when 1)
//   hready_def      out default-slave HREADYOUT (registered)
//   hresp_def       out default-slave HRESP (registered)
// ---------------------------------------------------------------------------
module ahb_default_slave
  import AHB_package::*;
(
  input  logic      hclk,
  input  logic      hreset_n,
  input  logic      default_slv_sel,
  input  logic      hready,
  output logic      hready_def,
  output hresp_type hresp_def
);

  def_slv_state_t r_state;
  logic           r_hready_def;
  hresp_type      r_hresp_def;
  logic           w_accept_err;

  // An unmapped access is only owed a response once its address phase is accepted.
  assign w_accept_err = hready & default_slv_sel;

  // Outputs are loaded together with the state they belong to, so they come
  // straight from flops.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state      <= DS_IDLE;
      r_hready_def <= 1'b1;
      r_hresp_def  <= OKAY;
    end else begin
      case (r_state)
        DS_IDLE: begin
          if (w_accept_err) begin
            r_state      <= DS_ERR1;
            r_hready_def <= 1'b0;
            r_hresp_def  <= ERROR;
          end
        end
        DS_ERR1: begin
          r_state      <= DS_ERR2;
          r_hready_def <= 1'b1;
          r_hresp_def  <= ERROR;
        end
        DS_ERR2: begin
          // A new unmapped access accepted in the final ERROR cycle starts
          // the next error immediately, with no OKAY cycle in between.
          if (w_accept_err) begin
            r_state      <= DS_ERR1;
            r_hready_def <= 1'b0;
            r_hresp_def  <= ERROR;
          end else begin
            r_state      <= DS_IDLE;
            r_hready_def <= 1'b1;
            r_hresp_def  <= OKAY;
          end
        end
        default: begin
          r_state      <= DS_IDLE;
          r_hready_def <= 1'b1;
          r_hresp_def  <= OKAY;
        end
      endcase
    end
  end

  assign hready_def = r_hready_def;
  assign hresp_def  = r_hresp_def;

endmodule

// File: rtl/ahb_decoder_ms.sv
// ---------------------------------------------------------------------------
// ahb_decoder_ms
// Per-master AHB address decoder. Matches HADDR against SLAVE_NUM inclusive
// [low, high] regions, drives a one-hot address-phase request, registers the
// data-phase selection for response muxing and hosts a default slave that
// errors unmapped accesses. hremap redirects region 0 to slave REMAP_SLV.
// Ports:
//   hclk, hreset_n   clock, async active-low reset
//   haddr, htrans    address-phase address and transfer type
//   hready           global HREADY
//   hremap           remap enable
//   hreq             one-hot address-phase slave request (combinational)
//   default_slv_sel  address phase hits no region (combinational)
//   hsel_data        registered one-hot data-phase slave select
//   def_sel_data     registered: default slave owns the data phase
//   hready_def       default-slave HREADYOUT
//   hresp_def        default-slave HRESP
// ---------------------------------------------------------------------------
module ahb_decoder_ms
  import AHB_package::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_NUM      = 4,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR  = '0,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR = '0,
  parameter int REMAP_SLV      = 0
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hready,
  input  logic                      hremap,
  output logic [SLAVE_NUM-1:0]      hreq,
  output logic                      default_slv_sel,
  output logic [SLAVE_NUM-1:0]      hsel_data,
  output logic                      def_sel_data,
  output logic                      hready_def,
  output hresp_type                 hresp_def
);

  function automatic logic f_in_range(
    input logic [AHB_ADDR_WIDTH-1:0] addr,
    input logic [AHB_ADDR_WIDTH-1:0] lo,
    input logic [AHB_ADDR_WIDTH-1:0] hi
  );
    return (addr >= lo) && (addr <= hi);
  endfunction

  logic                 w_active;
  logic [SLAVE_NUM-1:0] w_match;
  logic [SLAVE_NUM-1:0] w_win;
  logic [SLAVE_NUM:0]   w_lower_hit;  // w_lower_hit[i]: some region below i matched
  logic [SLAVE_NUM-1:0] w_hreq;
  logic                 w_default_sel;
  logic [SLAVE_NUM-1:0] r_hsel_data;
  logic                 r_def_sel_data;

  assign w_active       = (htrans == NONSEQ) || (htrans == SEQ);
  assign w_lower_hit[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < SLAVE_NUM; gi++) begin : g_region
      assign w_match[gi]       = f_in_range(haddr, LOW_ADDR[gi], HIGH_ADDR[gi]);
      // Lowest matching region wins, keeping the request one-hot when maps overlap.
      assign w_win[gi]         = w_match[gi] & ~w_lower_hit[gi];
      assign w_lower_hit[gi+1] = w_lower_hit[gi] | w_match[gi];
      // Region 0 is steered to slave REMAP_SLV while remapped; every other
      // region always drives its own slave bit.
      assign w_hreq[gi] = w_active &
                          ((w_win[gi] & ((gi != 0) | ~hremap)) |
                           (w_win[0] & hremap & (gi == REMAP_SLV)));
    end
  endgenerate

  assign w_default_sel = w_active & ~w_lower_hit[SLAVE_NUM];

  // Data-phase ownership advances only when the bus accepts the address phase.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_hsel_data    <= '0;
      r_def_sel_data <= 1'b0;
    end else if (hready) begin
      r_hsel_data    <= w_hreq;
      r_def_sel_data <= w_default_sel;
    end
  end

  ahb_default_slave u_default_slave (
    .hclk            (hclk),
    .hreset_n        (hreset_n),
    .default_slv_sel (w_default_sel),
    .hready          (hready),
    .hready_def      (hready_def),
    .hresp_def       (hresp_def)
  );

  assign hreq            = w_hreq;
  assign default_slv_sel = w_default_sel;
  assign hsel_data       = r_hsel_data;
  assign def_sel_data    = r_def_sel_data;

endmodule

// File: tb/tb_ahb_decoder_ms.sv
module tb_ahb_decoder_ms;
  import AHB_package::*;

  localparam int AW = 32;
  localparam int SN = 4;

  logic          hclk;
  logic          hreset_n;
  logic [AW-1:0] haddr;
  htrans_type    htrans;
  logic          hready;
  logic          hremap;
  logic [SN-1:0] hreq;
  logic          default_slv_sel;
  logic [SN-1:0] hsel_data;
  logic          def_sel_data;
  logic          hready_def;
  hresp_type     hresp_def;

  int vectors;
  int miscompares;

  ahb_decoder_ms #(
    .AHB_ADDR_WIDTH (AW),
    .SLAVE_NUM      (SN),
    .LOW_ADDR       ({32'h0000_5000, 32'h0000_2404, 32'h0000_0400, 32'h0000_0000}),
    .HIGH_ADDR      ({32'h0000_5FFF, 32'h0000_24FF, 32'h0000_0CF0, 32'h0000_03FF}),
    .REMAP_SLV      (2)
  ) dut (
    .hclk            (hclk),
    .hreset_n        (hreset_n),
    .haddr           (haddr),
    .htrans          (htrans),
    .hready          (hready),
    .hremap          (hremap),
    .hreq            (hreq),
    .default_slv_sel (default_slv_sel),
    .hsel_data       (hsel_data),
    .def_sel_data    (def_sel_data),
    .hready_def      (hready_def),
    .hresp_def       (hresp_def)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Drive one address phase and report it.
  task automatic drive(input htrans_type t, input logic [AW-1:0] a, input logic rdy);
    htrans = t;
    haddr  = a;
    hready = rdy;
    $display("[%0t] txn htrans=%0d haddr=0x%08h hready=%0b hremap=%0b",
             $time, t, a, rdy, hremap);
  endtask

  task automatic test_reset();
    vectors++;
    if (hsel_data !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_hsel_data: got %b, expected 0000", hsel_data);
    end
    vectors++;
    if (def_sel_data !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_def_sel_data: got %b, expected 0", def_sel_data);
    end
    vectors++;
    if (hready_def !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hready_def: got %b, expected 1", hready_def);
    end
    vectors++;
    if (hresp_def !== OKAY) begin
      miscompares++;
      $display("FAIL reset_hresp_def: got %0d, expected %0d", hresp_def, OKAY);
    end
  endtask

  task automatic test_decode_bounds();
    logic [AW-1:0] addr_tab [8];
    logic [SN-1:0] exp_tab  [8];
    logic [AW-1:0] miss_tab [4];
    addr_tab = '{32'h0400, 32'h03FF, 32'h0000, 32'h0CF0,
                 32'h2404, 32'h24FF, 32'h5000, 32'h5FFF};
    exp_tab  = '{4'b0010, 4'b0001, 4'b0001, 4'b0010,
                 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    miss_tab = '{32'h0CF1, 32'h2403, 32'h2500, 32'h6000};
    for (int i = 0; i < 8; i++) begin
      drive(NONSEQ, addr_tab[i], 1'b1);
      #1;
      vectors++;
      if (hreq !== exp_tab[i] || default_slv_sel !== 1'b0) begin
        miscompares++;
        $display("FAIL bounds_hreq[0x%08h]: got hreq=%b def=%b, expected hreq=%b def=0",
                 addr_tab[i], hreq, default_slv_sel, exp_tab[i]);
      end
      step();
      vectors++;
      if (hsel_data !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL bounds_hsel_data[0x%08h]: got %b, expected %b",
                 addr_tab[i], hsel_data, exp_tab[i]);
      end
    end
    // Just outside each region, probed without acceptance so no error starts.
    for (int i = 0; i < 4; i++) begin
      drive(NONSEQ, miss_tab[i], 1'b0);
      #1;
      vectors++;
      if (hreq !== 4'b0000 || default_slv_sel !== 1'b1) begin
        miscompares++;
        $display("FAIL miss_decode[0x%08h]: got hreq=%b def=%b, expected hreq=0000 def=1",
                 miss_tab[i], hreq, default_slv_sel);
      end
    end
    drive(IDLE, 32'h0000, 1'b1);
    step();
  endtask

  task automatic test_error();
    drive(NONSEQ, 32'h1000, 1'b1);
    #1;
    vectors++;
    if (default_slv_sel !== 1'b1 || hreq !== 4'b0000) begin
      miscompares++;
      $display("FAIL err_decode: got def=%b hreq=%b, expected def=1 hreq=0000",
               default_slv_sel, hreq);
    end
    step();
    vectors++;
    if (hready_def !== 1'b0 || hresp_def !== ERROR || def_sel_data !== 1'b1) begin
      miscompares++;
      $display("FAIL err_cycle1: got hready_def=%b hresp=%0d def_sel_data=%b, expected 0 %0d 1",
               hready_def, hresp_def, def_sel_data, ERROR);
    end
    drive(IDLE, 32'h0000, 1'b0);
    step();
    vectors++;
    if (hready_def !== 1'b1 || hresp_def !== ERROR || def_sel_data !== 1'b1) begin
      miscompares++;
      $display("FAIL err_cycle2: got hready_def=%b hresp=%0d def_sel_data=%b, expected 1 %0d 1",
               hready_def, hresp_def, def_sel_data, ERROR);
    end
    drive(IDLE, 32'h0000, 1'b1);
    step();
    vectors++;
    if (hready_def !== 1'b1 || hresp_def !== OKAY || def_sel_data !== 1'b0) begin
      miscompares++;
      $display("FAIL err_done: got hready_def=%b hresp=%0d def_sel_data=%b, expected 1 %0d 0",
               hready_def, hresp_def, def_sel_data, OKAY);
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_rdy  [5];
    hresp_type  exp_resp [5];
    htrans_type nxt_t    [5];
    logic       nxt_rdy  [5];
    exp_rdy  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_resp = '{ERROR, ERROR, ERROR, ERROR, OKAY};
    nxt_t    = '{NONSEQ, NONSEQ, IDLE, IDLE, IDLE};
    nxt_rdy  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    drive(NONSEQ, 32'h6000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (hready_def !== exp_rdy[i] || hresp_def !== exp_resp[i]) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got hready_def=%b hresp=%0d, expected %b %0d",
                 i, hready_def, hresp_def, exp_rdy[i], exp_resp[i]);
      end
      drive(nxt_t[i], 32'h7000, nxt_rdy[i]);
    end
    step();
  endtask

  task automatic test_remap();
    hremap = 1'b1;
    drive(NONSEQ, 32'h0010, 1'b1);
    #1;
    vectors++;
    if (hreq !== 4'b0100) begin
      miscompares++;
      $display("FAIL remap_on_hreq: got %b, expected 0100", hreq);
    end
    step();
    vectors++;
    if (hsel_data !== 4'b0100) begin
      miscompares++;
      $display("FAIL remap_on_hsel: got %b, expected 0100", hsel_data);
    end
    hremap = 1'b0;
    drive(NONSEQ, 32'h0010, 1'b0);
    #1;
    vectors++;
    if (hreq !== 4'b0001) begin
      miscompares++;
      $display("FAIL remap_off_hreq: got %b, expected 0001", hreq);
    end
    step();
    vectors++;
    if (hsel_data !== 4'b0100) begin
      miscompares++;
      $display("FAIL remap_data_kept: got %b, expected 0100", hsel_data);
    end
    drive(NONSEQ, 32'h0010, 1'b1);
    step();
    vectors++;
    if (hsel_data !== 4'b0001) begin
      miscompares++;
      $display("FAIL remap_off_hsel: got %b, expected 0001", hsel_data);
    end
  endtask

  task automatic test_hready_hold();
    drive(NONSEQ, 32'h0400, 1'b1);
    step();
    vectors++;
    if (hsel_data !== 4'b0010) begin
      miscompares++;
      $display("FAIL hold_setup: got %b, expected 0010", hsel_data);
    end
    drive(NONSEQ, 32'h5000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (hreq !== 4'b1000) begin
        miscompares++;
        $display("FAIL hold_hreq%0d: got %b, expected 1000", i, hreq);
      end
      step();
      vectors++;
      if (hsel_data !== 4'b0010) begin
        miscompares++;
        $display("FAIL hold_hsel%0d: got %b, expected 0010", i, hsel_data);
      end
    end
    drive(NONSEQ, 32'h5000, 1'b1);
    step();
    vectors++;
    if (hsel_data !== 4'b1000) begin
      miscompares++;
      $display("FAIL hold_release: got %b, expected 1000", hsel_data);
    end
  endtask

  task automatic test_busy_and_reset();
    drive(BUSY, 32'h1000, 1'b1);
    #1;
    vectors++;
    if (default_slv_sel !== 1'b0 || hreq !== 4'b0000) begin
      miscompares++;
      $display("FAIL busy_decode: got def=%b hreq=%b, expected 0 0000", default_slv_sel, hreq);
    end
    step();
    vectors++;
    if (hready_def !== 1'b1 || hresp_def !== OKAY || def_sel_data !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_no_error: got hready_def=%b hresp=%0d def_sel_data=%b, expected 1 %0d 0",
               hready_def, hresp_def, def_sel_data, OKAY);
    end
    drive(IDLE, 32'h0400, 1'b1);
    #1;
    vectors++;
    if (hreq !== 4'b0000 || default_slv_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_decode: got hreq=%b def=%b, expected 0000 0", hreq, default_slv_sel);
    end
    drive(SEQ, 32'h5FFF, 1'b1);
    #1;
    vectors++;
    if (hreq !== 4'b1000) begin
      miscompares++;
      $display("FAIL seq_decode: got %b, expected 1000", hreq);
    end
    step();
    drive(NONSEQ, 32'h1000, 1'b1);
    step();
    vectors++;
    if (hready_def !== 1'b0 || hresp_def !== ERROR || def_sel_data !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_err1: got hready_def=%b hresp=%0d def_sel_data=%b, expected 0 %0d 1",
               hready_def, hresp_def, def_sel_data, ERROR);
    end
    drive(IDLE, 32'h0000, 1'b0);
    #2;
    hreset_n = 1'b0;
    #1;
    vectors++;
    if (hready_def !== 1'b1 || hresp_def !== OKAY || def_sel_data !== 1'b0 || hsel_data !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_mid_err: got hready_def=%b hresp=%0d def_sel_data=%b hsel_data=%b, expected 1 %0d 0 0000",
               hready_def, hresp_def, def_sel_data, hsel_data, OKAY);
    end
    step();
    hreset_n = 1'b1;
    hready   = 1'b1;
    step();
    vectors++;
    if (hready_def !== 1'b1 || hresp_def !== OKAY) begin
      miscompares++;
      $display("FAIL rst_release: got hready_def=%b hresp=%0d, expected 1 %0d",
               hready_def, hresp_def, OKAY);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hreset_n    = 1'b0;
    haddr       = '0;
    htrans      = IDLE;
    hready      = 1'b1;
    hremap      = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    test_reset();
    hreset_n = 1'b1;
    step();
    test_decode_bounds();
    test_error();
    test_back_to_back();
    test_remap();
    test_hready_hold();
    test_busy_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
